// File: rtl/param_sync_fifo.sv
// Single-clock parametrised FIFO with occupancy level, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and a synchronous flush.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through read data;
// without it rd_data is a register loaded on each accepted read.
module param_sync_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("param_sync_fifo: DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the registered flags; level is the single source of truth for flags.
    always_comb begin
        wr_acc    = wr_en && !full;
        rd_acc    = rd_en && !empty;
        level_nxt = level;
        if (clear) begin
            level_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level_nxt = level + LW'(1);
                2'b01:   level_nxt = level - LW'(1);
                default: level_nxt = level;
            endcase
        end
    end

    // Pointers, level, and flags registered from the next level so they track it with no lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
                if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
            end
            level        <= level_nxt;
            full         <= (level_nxt == LW'(DEPTH));
            almost_full  <= (level_nxt >= LW'(AF_THRESH));
            empty        <= (level_nxt == '0);
            almost_empty <= (level_nxt <= LW'(AE_THRESH));
            overflow     <= !clear && wr_en && full;
            underflow    <= !clear && rd_en && empty;
        end
    end

    // Storage array; not reset, and a flush discards any write in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_acc && !clear) mem[wr_ptr] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally; rd_en only acknowledges it.
    assign rd_data = mem[rd_ptr];
`else
    // Registered read port: loads the head word on each accepted read, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_acc && !clear) begin
            rd_data <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo (WIDTH=16, DEPTH=8, AF=6, AE=2) with a
// reference level model and a data scoreboard; works with or without SYNC_FIFO_FWFT_EN.
module tb_param_sync_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] rd_data;
    logic             full, almost_full, empty, almost_empty, overflow, underflow;
    logic [LW-1:0]    level;

    int               n_cmp  = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] sb [$];
    int               m_level = 0;
    logic [WIDTH-1:0] wd = 16'h0100;
`ifndef SYNC_FIFO_FWFT_EN
    logic [WIDTH-1:0] m_rd_last = '0;
`endif

    param_sync_fifo #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags(input logic eo, input logic eu);
        check("level",        32'(level),        32'(m_level));
        check("empty",        32'(empty),        32'(m_level == 0));
        check("full",         32'(full),         32'(m_level == DEPTH));
        check("almost_empty", 32'(almost_empty), 32'(m_level <= AE));
        check("almost_full",  32'(almost_full),  32'(m_level >= AF));
        check("overflow",     32'(overflow),     32'(eo));
        check("underflow",    32'(underflow),    32'(eu));
    endtask

    task automatic check_reset_outputs();
        check("rst_level",        32'(level),        32'd0);
        check("rst_empty",        32'(empty),        32'd1);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_full",         32'(full),         32'd0);
        check("rst_almost_full",  32'(almost_full),  32'd0);
        check("rst_overflow",     32'(overflow),     32'd0);
        check("rst_underflow",    32'(underflow),    32'd0);
`ifndef SYNC_FIFO_FWFT_EN
        check("rst_rd_data",      32'(rd_data),      32'd0);
`endif
    endtask

    task automatic model_reset();
        sb.delete();
        m_level = 0;
`ifndef SYNC_FIFO_FWFT_EN
        m_rd_last = '0;
`endif
    endtask

    // One clock of stimulus; entered and left at posedge+1.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic c);
        logic             wacc, racc, eo, eu;
        logic [WIDTH-1:0] hd;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clear   = c;
        wacc = w && (m_level < DEPTH);
        racc = r && (m_level > 0);
        eo   = !c && w && (m_level == DEPTH);
        eu   = !c && r && (m_level == 0);
        hd   = '0;
        if (racc && !c) hd = sb.pop_front();
`ifdef SYNC_FIFO_FWFT_EN
        if (racc && !c) begin
            #1;
            check("rd_data_head", 32'(rd_data), 32'(hd));
        end
`endif
        @(posedge clk);
        #1;
        if (c) begin
            sb.delete();
            m_level = 0;
        end else begin
            if (wacc) begin
                sb.push_back(d);
                m_level++;
            end
            if (racc) m_level--;
        end
`ifndef SYNC_FIFO_FWFT_EN
        if (racc && !c) m_rd_last = hd;
        check("rd_data", 32'(rd_data), 32'(m_rd_last));
`endif
        check_flags(eo, eu);
        wr_en = 1'b0;
        rd_en = 1'b0;
        clear = 1'b0;
    endtask

    task automatic wr(input logic [WIDTH-1:0] d);
        cycle(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill 1..8, then a write into a full FIFO
        for (int i = 1; i <= 8; i++) wr(16'(i));
        wr(16'h0009);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Drain 8, then a read from an empty FIFO
        for (int i = 0; i < 8; i++) rd();
        rd();
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Pointer wrap: 4 rounds of write 5 / read 5
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) begin
                wr(wd);
                wd++;
            end
            for (int i = 0; i < 5; i++) rd();
        end

        // Full with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) begin
            wr(wd);
            wd++;
        end
        cycle(1'b1, 16'hDEAD, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) rd();

        // Empty with simultaneous read and write
        cycle(1'b1, 16'hBEEF, 1'b1, 1'b0);
        rd();

        // Steady-state streaming at level 4
        for (int i = 0; i < 4; i++) begin
            wr(wd);
            wd++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, wd, 1'b1, 1'b0);
            wd++;
        end
        for (int i = 0; i < 4; i++) rd();

        // Flush with a concurrent write at level 5
        for (int i = 0; i < 5; i++) begin
            wr(wd);
            wd++;
        end
        cycle(1'b1, 16'h5555, 1'b1, 1'b1);
        wr(16'h0A0A);
        rd();

        // Asynchronous reset in the middle of a write burst
        for (int i = 0; i < 3; i++) begin
            wr(wd);
            wd++;
        end
        wr_en   = 1'b1;
        wr_data = 16'h7777;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk);
        #1;
        check_reset_outputs();
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Operation resumes cleanly after reset
        wr(16'h1234);
        wr(16'h5678);
        rd();
        rd();
        rd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
